// File: rtl/eth_buffer_pkg.sv
// Shared constants, read-size encoding and alignment helper for the Ethernet
// receive frame buffer.
package eth_buffer_pkg;

   localparam int els_lp        = 2048;
   localparam int addr_width_lp = 11;
   localparam int size_width_lp = 16;

   typedef enum logic [1:0] {
      op_byte   = 2'd0,
      op_half   = 2'd1,
      op_word   = 2'd2,
      op_double = 2'd3
   } op_size_e;

   // True when the byte offset is not a multiple of the access size.
   function automatic logic misaligned(input logic [2:0] addr_lsbs, input op_size_e op);
      logic [2:0] mask;
      case (op)
         op_byte: mask = 3'b000;
         op_half: mask = 3'b001;
         op_word: mask = 3'b011;
         default: mask = 3'b111;
      endcase
      return |(addr_lsbs & mask);
   endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous RAM: one read or one write per cycle, registered read
// data that holds until the next read.
module bsg_mem_1rw_sync #(
   parameter int width_p = 64,
   parameter int els_p   = 256,
   localparam int addr_width_lp = $clog2(els_p)
) (
   input  logic                     clk_i,
   input  logic [width_p-1:0]       data_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic                     v_i,
   input  logic                     w_i,
   output logic [width_p-1:0]       data_o
);

   logic [width_p-1:0] mem_reg [els_p];

   always_ff @(posedge clk_i) begin
      if (v_i & w_i)
         mem_reg[addr_i] <= data_i;
      if (v_i & ~w_i)
         data_o <= mem_reg[addr_i];
   end

endmodule

// File: rtl/rx_read_align.sv
// Shifts the registered memory word down to the requested byte lane and
// zero-extends it to the access size; errored reads return zero.
module rx_read_align
   import eth_buffer_pkg::*;
#(
   parameter int data_width_p = 64,
   localparam int lsb_lp = $clog2(data_width_p / 8)
) (
   input  logic [lsb_lp-1:0]       offset_i,
   input  op_size_e                op_size_i,
   input  logic                    err_i,
   input  logic [data_width_p-1:0] word_i,
   output logic [data_width_p-1:0] data_o
);

   logic [data_width_p-1:0] shifted;

   always_comb begin
      shifted = word_i >> {offset_i, 3'b000};
      data_o  = '0;
      if (!err_i) begin
         case (op_size_i)
            op_byte: data_o[7:0]  = shifted[7:0];
            op_half: data_o[15:0] = shifted[15:0];
            op_word: data_o[31:0] = shifted[31:0];
            default: data_o       = shifted;
         endcase
      end
   end

endmodule

// File: rtl/rx_buffer_memory.sv
// Receive frame buffer: MAC fills and commits slots in order, PL reads the head
// slot with sub-word granularity and releases it; bad commits are counted.
module rx_buffer_memory
   import eth_buffer_pkg::*;
#(
   parameter int slot_p       = 2,
   parameter int data_width_p = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   output logic                     write_slot_ready_and_o,
   input  logic                     write_v_i,
   input  logic [addr_width_lp-1:0] write_addr_i,
   input  logic [data_width_p-1:0]  write_data_i,
   input  logic                     write_commit_v_i,
   input  logic [size_width_lp-1:0] write_size_i,
   input  logic                     write_abort_i,
   output logic                     read_slot_v_o,
   output logic [size_width_lp-1:0] read_size_r_o,
   input  logic                     read_v_i,
   input  logic [addr_width_lp-1:0] read_addr_i,
   input  logic [1:0]               read_op_size_i,
   output logic [data_width_p-1:0]  read_data_r_o,
   output logic                     read_err_r_o,
   input  logic                     read_slot_yumi_i,
   output logic [size_width_lp-1:0] drop_count_o
);

   localparam int bytes_lp        = data_width_p / 8;
   localparam int lsb_lp          = $clog2(bytes_lp);
   localparam int words_lp        = els_lp / bytes_lp;
   localparam int word_addr_lp    = addr_width_lp - lsb_lp;
   localparam int ptr_width_lp    = (slot_p > 1) ? $clog2(slot_p) : 1;
   localparam int count_width_lp  = $clog2(slot_p + 1);

   logic [ptr_width_lp-1:0]   wptr_reg, rptr_reg;
   logic [count_width_lp-1:0] count_reg;
   logic [size_width_lp-1:0]  drop_count_reg;

   logic [slot_p-1:0]         rd_sel_reg;
   logic [lsb_lp-1:0]         rd_offset_reg;
   op_size_e                  rd_op_reg;
   logic                      rd_err_reg;

   logic [slot_p-1:0]         wptr_onehot, rptr_onehot;
   logic [data_width_p-1:0]   mem_data [slot_p];
   logic [size_width_lp-1:0]  slot_size [slot_p];
   logic [data_width_p-1:0]   raw_word;

   logic write_fire, read_fire, pop, size_ok, commit_good, commit_drop;
   logic rd_err_next;
   op_size_e read_op;
   logic unused_write_lsbs;

   function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
      return (p == ptr_width_lp'(slot_p - 1)) ? '0 : p + 1'b1;
   endfunction

   // Writes are whole aligned words, so the low address bits carry no information.
   assign unused_write_lsbs = |write_addr_i[lsb_lp-1:0];

   assign write_slot_ready_and_o = (count_reg != count_width_lp'(slot_p));
   assign read_slot_v_o          = (count_reg != '0);

   assign write_fire  = write_v_i & write_slot_ready_and_o;
   assign read_fire   = read_v_i & read_slot_v_o;
   assign pop         = read_slot_yumi_i & read_slot_v_o;
   assign size_ok     = (write_size_i != '0) && (write_size_i <= size_width_lp'(els_lp));
   assign commit_good = write_commit_v_i & ~write_abort_i & write_slot_ready_and_o & size_ok;
   assign commit_drop = write_commit_v_i & ~write_abort_i & ~(write_slot_ready_and_o & size_ok);

   assign read_op     = op_size_e'(read_op_size_i);
   assign rd_err_next = misaligned(read_addr_i[2:0], read_op)
                      | ((read_op == op_double) && (data_width_p == 32));

   genvar gi;
   generate
      for (gi = 0; gi < slot_p; gi++) begin : g_slot
         logic                     we, re;
         logic [word_addr_lp-1:0]  addr;
         logic [size_width_lp-1:0] size_reg;

         assign wptr_onehot[gi] = (wptr_reg == ptr_width_lp'(gi));
         assign rptr_onehot[gi] = (rptr_reg == ptr_width_lp'(gi));
         assign we   = write_fire & wptr_onehot[gi];
         assign re   = read_fire & rptr_onehot[gi];
         assign addr = we ? write_addr_i[addr_width_lp-1:lsb_lp]
                          : read_addr_i[addr_width_lp-1:lsb_lp];

         bsg_mem_1rw_sync #(
            .width_p (data_width_p),
            .els_p   (words_lp)
         ) mem (
            .clk_i  (clk_i),
            .data_i (write_data_i),
            .addr_i (addr),
            .v_i    (we | re),
            .w_i    (we),
            .data_o (mem_data[gi])
         );

         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i)
               size_reg <= '0;
            else if (commit_good && wptr_onehot[gi])
               size_reg <= write_size_i;
         end

         assign slot_size[gi] = size_reg;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_reg       <= '0;
         rptr_reg       <= '0;
         count_reg      <= '0;
         drop_count_reg <= '0;
      end else begin
         if (commit_good)
            wptr_reg <= ptr_inc(wptr_reg);
         if (pop)
            rptr_reg <= ptr_inc(rptr_reg);
         if (commit_good && !pop)
            count_reg <= count_reg + 1'b1;
         else if (pop && !commit_good)
            count_reg <= count_reg - 1'b1;
         if (commit_drop && (drop_count_reg != '1))
            drop_count_reg <= drop_count_reg + 1'b1;
      end
   end

   // Slot select is captured at acceptance so a same-cycle yumi cannot redirect the data.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_sel_reg    <= '0;
         rd_offset_reg <= '0;
         rd_op_reg     <= op_byte;
         rd_err_reg    <= 1'b0;
      end else if (read_fire) begin
         rd_sel_reg    <= rptr_onehot;
         rd_offset_reg <= read_addr_i[lsb_lp-1:0];
         rd_op_reg     <= read_op;
         rd_err_reg    <= rd_err_next;
      end
   end

   always_comb begin
      raw_word      = '0;
      read_size_r_o = '0;
      for (int i = 0; i < slot_p; i++) begin
         if (rd_sel_reg[i])
            raw_word = raw_word | mem_data[i];
         if (rptr_onehot[i] && read_slot_v_o)
            read_size_r_o = read_size_r_o | slot_size[i];
      end
   end

   rx_read_align #(
      .data_width_p (data_width_p)
   ) align (
      .offset_i  (rd_offset_reg),
      .op_size_i (rd_op_reg),
      .err_i     (rd_err_reg),
      .word_i    (raw_word),
      .data_o    (read_data_r_o)
   );

   assign read_err_r_o = rd_err_reg;
   assign drop_count_o = drop_count_reg;

endmodule

// File: tb/tb_rx_buffer_memory.sv
// Directed bench for rx_buffer_memory with default parameters (2 slots, 64-bit words).
module tb_rx_buffer_memory;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        write_slot_ready_and_o;
   logic        write_v_i;
   logic [10:0] write_addr_i;
   logic [63:0] write_data_i;
   logic        write_commit_v_i;
   logic [15:0] write_size_i;
   logic        write_abort_i;
   logic        read_slot_v_o;
   logic [15:0] read_size_r_o;
   logic        read_v_i;
   logic [10:0] read_addr_i;
   logic [1:0]  read_op_size_i;
   logic [63:0] read_data_r_o;
   logic        read_err_r_o;
   logic        read_slot_yumi_i;
   logic [15:0] drop_count_o;

   int checks = 0;
   int errors = 0;

   rx_buffer_memory dut (
      .clk_i                  (clk_i),
      .reset_i                (reset_i),
      .write_slot_ready_and_o (write_slot_ready_and_o),
      .write_v_i              (write_v_i),
      .write_addr_i           (write_addr_i),
      .write_data_i           (write_data_i),
      .write_commit_v_i       (write_commit_v_i),
      .write_size_i           (write_size_i),
      .write_abort_i          (write_abort_i),
      .read_slot_v_o          (read_slot_v_o),
      .read_size_r_o          (read_size_r_o),
      .read_v_i               (read_v_i),
      .read_addr_i            (read_addr_i),
      .read_op_size_i         (read_op_size_i),
      .read_data_r_o          (read_data_r_o),
      .read_err_r_o           (read_err_r_o),
      .read_slot_yumi_i       (read_slot_yumi_i),
      .drop_count_o           (drop_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic write_word(input logic [10:0] a, input logic [63:0] d);
      write_v_i = 1'b1; write_addr_i = a; write_data_i = d;
      step();
      write_v_i = 1'b0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic commit(input logic [15:0] sz, input logic abort, input logic yumi);
      write_commit_v_i = 1'b1; write_size_i = sz; write_abort_i = abort; read_slot_yumi_i = yumi;
      step();
      write_commit_v_i = 1'b0; write_abort_i = 1'b0; read_slot_yumi_i = 1'b0;
      $display("commit size=%0d abort=%0b yumi=%0b drop=%0d", sz, abort, yumi, drop_count_o);
   endtask

   task automatic yumi();
      read_slot_yumi_i = 1'b1;
      step();
      read_slot_yumi_i = 1'b0;
      $display("yumi v=%0b size=%0d", read_slot_v_o, read_size_r_o);
   endtask

   task automatic rd(input logic [10:0] a, input logic [1:0] op);
      read_v_i = 1'b1; read_addr_i = a; read_op_size_i = op;
      step();
      read_v_i = 1'b0;
      $display("read addr=%0d op=%0d data=%h err=%0b", a, op, read_data_r_o, read_err_r_o);
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (2) step();
      reset_i = 1'b0;
      step();
      checks++; if (write_slot_ready_and_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", write_slot_ready_and_o); end
      checks++; if (read_slot_v_o !== 1'b0) begin errors++; $display("FAIL reset_slot_v got=%0b exp=0", read_slot_v_o); end
      checks++; if (read_size_r_o !== 16'd0) begin errors++; $display("FAIL reset_size got=%0d exp=0", read_size_r_o); end
      checks++; if (read_data_r_o !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", read_data_r_o); end
      checks++; if (read_err_r_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", read_err_r_o); end
      checks++; if (drop_count_o !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_count_o); end
   endtask

   task automatic test_write_read();
      logic [7:0] b;
      for (int k = 0; k < 8; k++) begin
         b = 8'(8'h11 * (k + 1));
         write_word(11'(8 * k), {8{b}});
      end
      write_word(11'd64, 64'h8877665544332211);
      commit(16'd60, 1'b0, 1'b0);
      checks++; if (read_slot_v_o !== 1'b1) begin errors++; $display("FAIL commit_slot_v got=%0b exp=1", read_slot_v_o); end
      checks++; if (read_size_r_o !== 16'd60) begin errors++; $display("FAIL commit_size got=%0d exp=60", read_size_r_o); end
      rd(11'd9, 2'd0);
      checks++; if (read_data_r_o !== 64'h22 || read_err_r_o !== 1'b0) begin errors++; $display("FAIL byte_read got=%h/%0b exp=22/0", read_data_r_o, read_err_r_o); end
      rd(11'd3, 2'd1);
      checks++; if (read_data_r_o !== 64'd0 || read_err_r_o !== 1'b1) begin errors++; $display("FAIL half_misaligned got=%h/%0b exp=0/1", read_data_r_o, read_err_r_o); end
      rd(11'd68, 2'd2);
      checks++; if (read_data_r_o !== 64'h88776655 || read_err_r_o !== 1'b0) begin errors++; $display("FAIL word_read got=%h/%0b exp=88776655/0", read_data_r_o, read_err_r_o); end
      rd(11'd40, 2'd3);
      checks++; if (read_data_r_o !== 64'h6666666666666666) begin errors++; $display("FAIL double_read got=%h exp=6666666666666666", read_data_r_o); end
      rd(11'd14, 2'd1);
      checks++; if (read_data_r_o !== 64'h2222 || read_err_r_o !== 1'b0) begin errors++; $display("FAIL half_read got=%h/%0b exp=2222/0", read_data_r_o, read_err_r_o); end
      rd(11'd70, 2'd2);
      checks++; if (read_data_r_o !== 64'd0 || read_err_r_o !== 1'b1) begin errors++; $display("FAIL word_misaligned got=%h/%0b exp=0/1", read_data_r_o, read_err_r_o); end
   endtask

   task automatic test_full_drop();
      write_word(11'd0, 64'hBBBBBBBBBBBBBBBB);
      commit(16'd100, 1'b0, 1'b0);
      checks++; if (write_slot_ready_and_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", write_slot_ready_and_o); end
      checks++; if (read_size_r_o !== 16'd60) begin errors++; $display("FAIL full_head_size got=%0d exp=60", read_size_r_o); end
      write_word(11'd0, 64'hFFFFFFFFFFFFFFFF);
      commit(16'd200, 1'b0, 1'b0);
      checks++; if (drop_count_o !== 16'd1) begin errors++; $display("FAIL full_drop got=%0d exp=1", drop_count_o); end
      checks++; if (read_size_r_o !== 16'd60) begin errors++; $display("FAIL drop_size_kept got=%0d exp=60", read_size_r_o); end
      rd(11'd0, 2'd3);
      checks++; if (read_data_r_o !== 64'h1111111111111111) begin errors++; $display("FAIL full_write_ignored got=%h exp=1111111111111111", read_data_r_o); end
      commit(16'd300, 1'b0, 1'b1);
      checks++; if (drop_count_o !== 16'd2) begin errors++; $display("FAIL full_yumi_drop got=%0d exp=2", drop_count_o); end
      checks++; if (write_slot_ready_and_o !== 1'b1 || read_slot_v_o !== 1'b1) begin errors++; $display("FAIL after_yumi ready/v got=%0b/%0b exp=1/1", write_slot_ready_and_o, read_slot_v_o); end
      checks++; if (read_size_r_o !== 16'd100) begin errors++; $display("FAIL after_yumi_size got=%0d exp=100", read_size_r_o); end
   endtask

   task automatic test_commit_and_yumi();
      write_word(11'd0, 64'hC0FFEE0012345678);
      read_v_i = 1'b1; read_addr_i = 11'd0; read_op_size_i = 2'd3;
      commit(16'd32, 1'b0, 1'b1);
      read_v_i = 1'b0;
      checks++; if (read_data_r_o !== 64'hBBBBBBBBBBBBBBBB) begin errors++; $display("FAIL read_released_slot got=%h exp=BBBBBBBBBBBBBBBB", read_data_r_o); end
      checks++; if (read_slot_v_o !== 1'b1 || write_slot_ready_and_o !== 1'b1) begin errors++; $display("FAIL cy_count v/ready got=%0b/%0b exp=1/1", read_slot_v_o, write_slot_ready_and_o); end
      checks++; if (read_size_r_o !== 16'd32) begin errors++; $display("FAIL cy_head_size got=%0d exp=32", read_size_r_o); end
      rd(11'd0, 2'd3);
      checks++; if (read_data_r_o !== 64'hC0FFEE0012345678) begin errors++; $display("FAIL cy_head_data got=%h exp=C0FFEE0012345678", read_data_r_o); end
      rd(11'd3, 2'd0);
      checks++; if (read_data_r_o !== 64'h12) begin errors++; $display("FAIL cy_byte3 got=%h exp=12", read_data_r_o); end
   endtask

   task automatic test_abort();
      write_word(11'd0, 64'hDEADDEADDEADDEAD);
      write_abort_i = 1'b1;
      step();
      write_abort_i = 1'b0;
      checks++; if (drop_count_o !== 16'd2 || read_size_r_o !== 16'd32) begin errors++; $display("FAIL abort_state drop/size got=%0d/%0d exp=2/32", drop_count_o, read_size_r_o); end
      write_word(11'd0, 64'h0123456789ABCDEF);
      commit(16'd64, 1'b0, 1'b0);
      checks++; if (write_slot_ready_and_o !== 1'b0) begin errors++; $display("FAIL abort_full_ready got=%0b exp=0", write_slot_ready_and_o); end
      yumi();
      checks++; if (read_size_r_o !== 16'd64) begin errors++; $display("FAIL abort_next_size got=%0d exp=64", read_size_r_o); end
      rd(11'd0, 2'd3);
      checks++; if (read_data_r_o !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL abort_overwrite got=%h exp=0123456789ABCDEF", read_data_r_o); end
      commit(16'd0, 1'b0, 1'b0);
      checks++; if (drop_count_o !== 16'd3) begin errors++; $display("FAIL size0_drop got=%0d exp=3", drop_count_o); end
      commit(16'd2049, 1'b0, 1'b0);
      checks++; if (drop_count_o !== 16'd4) begin errors++; $display("FAIL oversize_drop got=%0d exp=4", drop_count_o); end
      commit(16'd100, 1'b1, 1'b0);
      checks++; if (drop_count_o !== 16'd4 || read_size_r_o !== 16'd64) begin errors++; $display("FAIL abort_commit drop/size got=%0d/%0d exp=4/64", drop_count_o, read_size_r_o); end
      yumi();
      checks++; if (read_slot_v_o !== 1'b0 || read_size_r_o !== 16'd0) begin errors++; $display("FAIL empty v/size got=%0b/%0d exp=0/0", read_slot_v_o, read_size_r_o); end
      rd(11'd1, 2'd1);
      checks++; if (read_data_r_o !== 64'h0123456789ABCDEF || read_err_r_o !== 1'b0) begin errors++; $display("FAIL empty_read_hold got=%h/%0b exp=0123456789ABCDEF/0", read_data_r_o, read_err_r_o); end
   endtask

   task automatic test_async_reset();
      write_word(11'd0, 64'h5555555555555555);
      commit(16'd8, 1'b0, 1'b0);
      rd(11'd1, 2'd1);
      checks++; if (read_err_r_o !== 1'b1 || read_size_r_o !== 16'd8) begin errors++; $display("FAIL pre_reset err/size got=%0b/%0d exp=1/8", read_err_r_o, read_size_r_o); end
      write_v_i = 1'b1; write_addr_i = 11'd8; write_data_i = 64'h7777777777777777;
      #2;
      reset_i = 1'b1;
      #1;
      checks++; if (write_slot_ready_and_o !== 1'b1 || read_slot_v_o !== 1'b0) begin errors++; $display("FAIL async_ready_v got=%0b/%0b exp=1/0", write_slot_ready_and_o, read_slot_v_o); end
      checks++; if (read_size_r_o !== 16'd0 || read_data_r_o !== 64'd0) begin errors++; $display("FAIL async_size_data got=%0d/%h exp=0/0", read_size_r_o, read_data_r_o); end
      checks++; if (read_err_r_o !== 1'b0 || drop_count_o !== 16'd0) begin errors++; $display("FAIL async_err_drop got=%0b/%0d exp=0/0", read_err_r_o, drop_count_o); end
      $display("async reset asserted mid-frame");
      write_v_i = 1'b0;
      step();
      reset_i = 1'b0;
      step();
      checks++; if (read_slot_v_o !== 1'b0 || write_slot_ready_and_o !== 1'b1) begin errors++; $display("FAIL post_reset v/ready got=%0b/%0b exp=0/1", read_slot_v_o, write_slot_ready_and_o); end
   endtask

   initial begin
      reset_i = 1'b1;
      write_v_i = 1'b0; write_addr_i = '0; write_data_i = '0;
      write_commit_v_i = 1'b0; write_size_i = '0; write_abort_i = 1'b0;
      read_v_i = 1'b0; read_addr_i = '0; read_op_size_i = '0; read_slot_yumi_i = 1'b0;
      test_reset();
      test_write_read();
      test_full_drop();
      test_commit_and_yumi();
      test_abort();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
